// File: rtl/float_pkg.sv
// Shared IEEE-754 constants, format helpers and FSM encodings for the float multiplier and divider.
package float_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        MUL  = 2'd2,
        NORM = 2'd3
    } state_t;

    localparam logic [63:0] NAN_VALUE_64 = 64'hFFF8_0000_0000_0000;
    localparam logic [63:0] NAN_VALUE_32 = 64'h0000_0000_FFC0_0000;
    localparam logic [63:0] INF_VALUE_64 = 64'h7FF0_0000_0000_0000;
    localparam logic [63:0] INF_VALUE_32 = 64'h0000_0000_7F80_0000;

    function automatic int unsigned exp_width(input int unsigned w);
        return (w == 64) ? 11 : 8;
    endfunction

    function automatic int unsigned frac_width(input int unsigned w);
        return (w == 64) ? 52 : 23;
    endfunction

    // Exponent bias (EXP_SHIFT) and all-ones exponent (EXP_MAX) for the chosen width.
    function automatic int unsigned exp_shift(input int unsigned w);
        return (1 << (exp_width(w) - 1)) - 1;
    endfunction

    function automatic int unsigned exp_max(input int unsigned w);
        return (1 << exp_width(w)) - 1;
    endfunction

    function automatic logic [63:0] nan_value(input int unsigned w);
        return (w == 64) ? NAN_VALUE_64 : NAN_VALUE_32;
    endfunction

    function automatic logic [63:0] inf_value(input int unsigned w);
        return (w == 64) ? INF_VALUE_64 : INF_VALUE_32;
    endfunction

endpackage

// File: rtl/float_classify.sv
// Per-operand IEEE-754 decode: zero (including flushed denormals), infinity and NaN.
module float_classify
    import float_pkg::*;
#(
    parameter int unsigned FLOAT_WIDTH = 64
) (
    input  logic [FLOAT_WIDTH-1:0] op,
    output logic                   zero_c,
    output logic                   inf_c,
    output logic                   nan_c
);

    localparam int unsigned E = exp_width(FLOAT_WIDTH);
    localparam int unsigned F = frac_width(FLOAT_WIDTH);

    logic [E-1:0] exp_f;
    logic [F-1:0] frac_f;
    logic         unused_sign;

    assign exp_f       = op[FLOAT_WIDTH-2 -: E];
    assign frac_f      = op[F-1:0];
    assign unused_sign = op[FLOAT_WIDTH-1];

    assign zero_c = (exp_f == '0);
    assign inf_c  = (exp_f == '1) && (frac_f == '0);
    assign nan_c  = (exp_f == '1) && (frac_f != '0);

endmodule

// File: rtl/mul_float.sv
// Sequential IEEE-754 multiplier (shift-add, one multiplier bit per cycle).
// Define MUL_FLOAT_ROUND_EN for round-to-nearest-even; otherwise the product is truncated.
module mul_float
    import float_pkg::*;
#(
    parameter int unsigned FLOAT_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [FLOAT_WIDTH-1:0] op1,
    input  logic [FLOAT_WIDTH-1:0] op2,
    output logic [FLOAT_WIDTH-1:0] out_reg,
    output logic                   nan_reg,
    output logic                   overflow_reg,
    output logic                   underflow_reg,
    output logic                   zero_reg,
    output logic                   busy,
    output logic                   done_reg
);

    localparam int unsigned W   = FLOAT_WIDTH;
    localparam int unsigned E   = exp_width(W);
    localparam int unsigned F   = frac_width(W);
    localparam int unsigned FW1 = F + 1;
    localparam int unsigned PW  = 2 * F + 2;
    localparam int unsigned XW  = E + 2;
    localparam int unsigned CW  = $clog2(F + 1);

    localparam logic [W-1:0]         NAN_V      = W'(nan_value(W));
    localparam logic [W-1:0]         INF_V      = W'(inf_value(W));
    localparam logic signed [XW-1:0] EXP_SHIFT_X = XW'(exp_shift(W));
    localparam logic signed [XW-1:0] EXP_MAX_X   = XW'(exp_max(W));
    localparam logic signed [XW-1:0] ZERO_X      = '0;

    state_t state, next_state;

    logic [W-1:0]         a_reg, b_reg;
    logic                 sign_r;
    logic signed [XW-1:0] exp_r;
    logic [PW-1:0]        mcand, prod;
    logic [F:0]           mplier;
    logic [CW-1:0]        cnt;
    logic                 norm_phase;
    logic signed [XW-1:0] n_exp;
    logic [F-1:0]         n_frac;

    logic capture_c, load_c, mul_c, round_c, finish_c;
    logic a_zero_c, a_inf_c, a_nan_c, b_zero_c, b_inf_c, b_nan_c;

    float_classify #(.FLOAT_WIDTH(W)) u_class_a (
        .op(a_reg), .zero_c(a_zero_c), .inf_c(a_inf_c), .nan_c(a_nan_c)
    );
    float_classify #(.FLOAT_WIDTH(W)) u_class_b (
        .op(b_reg), .zero_c(b_zero_c), .inf_c(b_inf_c), .nan_c(b_nan_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = LOAD;
            LOAD:    next_state = MUL;
            MUL:     if (cnt == CW'(F)) next_state = NORM;
            NORM:    if (norm_phase) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NORM takes two cycles: normalize/round, then special-case selection and output.
    always_comb begin
        capture_c = 1'b0;
        load_c    = 1'b0;
        mul_c     = 1'b0;
        round_c   = 1'b0;
        finish_c  = 1'b0;
        case (state)
            IDLE:    capture_c = start;
            LOAD:    load_c = 1'b1;
            MUL:     mul_c = 1'b1;
            NORM:    if (norm_phase) finish_c = 1'b1; else round_c = 1'b1;
            default: ;
        endcase
    end

    logic                 top_c;
    logic [F-1:0]         mant_c;
    logic signed [XW-1:0] exp_c;
    logic [F:0]           sum_c;

    assign top_c  = prod[PW-1];
    assign mant_c = top_c ? prod[2*F:F+1] : prod[2*F-1:F];
    assign exp_c  = exp_r + XW'(top_c);

`ifdef MUL_FLOAT_ROUND_EN
    logic guard_c, sticky_c;
    assign guard_c  = top_c ? prod[F] : prod[F-1];
    assign sticky_c = top_c ? (|prod[F-1:0]) : (|prod[F-2:0]);
    assign sum_c    = {1'b0, mant_c} + FW1'(guard_c & (sticky_c | mant_c[0]));
`else
    logic unused_lo;
    assign unused_lo = ^prod[F-1:0];
    assign sum_c     = {1'b0, mant_c};
`endif

    logic [W-1:0] res_c;
    logic         nan_c, ovf_c, unf_c, zero_c;

    always_comb begin
        res_c  = {sign_r, n_exp[E-1:0], n_frac};
        nan_c  = 1'b0;
        ovf_c  = 1'b0;
        unf_c  = 1'b0;
        zero_c = 1'b0;
        if (a_nan_c || b_nan_c || (a_inf_c && b_zero_c) || (b_inf_c && a_zero_c)) begin
            res_c = NAN_V;
            nan_c = 1'b1;
        end else if (a_inf_c || b_inf_c) begin
            res_c = INF_V | {sign_r, (W-1)'(0)};
        end else if (a_zero_c || b_zero_c) begin
            res_c  = {sign_r, (W-1)'(0)};
            zero_c = 1'b1;
        end else if (n_exp >= EXP_MAX_X) begin
            res_c = INF_V | {sign_r, (W-1)'(0)};
            ovf_c = 1'b1;
        end else if (n_exp <= ZERO_X) begin
            res_c  = {sign_r, (W-1)'(0)};
            unf_c  = 1'b1;
            zero_c = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg         <= '0;
            b_reg         <= '0;
            sign_r        <= 1'b0;
            exp_r         <= '0;
            mcand         <= '0;
            mplier        <= '0;
            prod          <= '0;
            cnt           <= '0;
            norm_phase    <= 1'b0;
            n_exp         <= '0;
            n_frac        <= '0;
            out_reg       <= '0;
            nan_reg       <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            zero_reg      <= 1'b0;
            busy          <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            busy     <= (next_state != IDLE);
            done_reg <= finish_c;
            if (capture_c) begin
                a_reg <= op1;
                b_reg <= op2;
            end
            if (load_c) begin
                sign_r     <= a_reg[W-1] ^ b_reg[W-1];
                exp_r      <= XW'(a_reg[W-2 -: E]) + XW'(b_reg[W-2 -: E]) - EXP_SHIFT_X;
                mcand      <= PW'({1'b1, a_reg[F-1:0]});
                mplier     <= {1'b1, b_reg[F-1:0]};
                prod       <= '0;
                cnt        <= '0;
                norm_phase <= 1'b0;
            end
            if (mul_c) begin
                if (mplier[0]) prod <= prod + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CW'(1);
            end
            // A rounding carry out of the fraction leaves it all-zero and bumps the exponent.
            if (round_c) begin
                n_frac     <= sum_c[F-1:0];
                n_exp      <= exp_c + XW'(sum_c[F]);
                norm_phase <= 1'b1;
            end
            if (finish_c) begin
                out_reg       <= res_c;
                nan_reg       <= nan_c;
                overflow_reg  <= ovf_c;
                underflow_reg <= unf_c;
                zero_reg      <= zero_c;
                norm_phase    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mul_float.sv
// Directed table-driven bench for mul_float at FLOAT_WIDTH=32, plus reset-abort and restart-while-busy sequences.
module tb_mul_float;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic [31:0] out_reg;
    logic        nan_reg, overflow_reg, underflow_reg, zero_reg, busy, done_reg;

    mul_float #(.FLOAT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op1(op1), .op2(op2),
        .out_reg(out_reg), .nan_reg(nan_reg), .overflow_reg(overflow_reg),
        .underflow_reg(underflow_reg), .zero_reg(zero_reg), .busy(busy), .done_reg(done_reg)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // flags are packed {nan, overflow, underflow, zero}
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [3:0]  f;
    } vec_t;

`ifdef MUL_FLOAT_ROUND_EN
    localparam logic [31:0] RND_RES = 32'h4010_0002;
`else
    localparam logic [31:0] RND_RES = 32'h4010_0001;
`endif

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    // Issue one operation; optionally re-pulse start (with other operands) restart_at edges in.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int restart_at,
                         output int lat, output logic busy_ok);
        @(negedge clk);
        op1 = a; op2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        busy_ok = busy;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done_reg) begin
                lat = i;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            if (i == restart_at) begin
                op1 = 32'h3F80_0000; op2 = 32'h3F80_0000; start = 1'b1;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   lat;
        logic bok;
        logic seen;

        vecs[0]  = '{32'h4040_0000, 32'h4020_0000, 32'h40F0_0000, 4'b0000};
        vecs[1]  = '{32'hC000_0000, 32'h3F00_0000, 32'hBF80_0000, 4'b0000};
        vecs[2]  = '{32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 4'b0000};
        vecs[3]  = '{32'h7F80_0000, 32'h0000_0000, 32'hFFC0_0000, 4'b1000};
        vecs[4]  = '{32'h7F00_0000, 32'h4080_0000, 32'h7F80_0000, 4'b0100};
        vecs[5]  = '{32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 4'b0011};
        vecs[6]  = '{32'h3FC0_0001, 32'h3FC0_0001, RND_RES,       4'b0000};
        vecs[7]  = '{32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 4'b0001};
        vecs[8]  = '{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 4'b0000};
        vecs[9]  = '{32'h7FC0_0001, 32'h3F80_0000, 32'hFFC0_0000, 4'b1000};
        vecs[10] = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 4'b0000};
        vecs[11] = '{32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 4'b0001};
        vecs[12] = '{32'hC040_0000, 32'hC040_0000, 32'h4110_0000, 4'b0000};

        #12;
        chk("reset_state", 64'({out_reg, nan_reg, overflow_reg, underflow_reg, zero_reg, busy, done_reg}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < NV; v++) begin
            do_op(vecs[v].a, vecs[v].b, 0, lat, bok);
            chk($sformatf("out[%0d]", v), 64'(out_reg), 64'(vecs[v].r));
            chk($sformatf("flags_busy[%0d]", v),
                64'({busy, nan_reg, overflow_reg, underflow_reg, zero_reg}), 64'({1'b0, vecs[v].f}));
            chk($sformatf("latency[%0d]", v), 64'(lat), 64'd27);
            chk($sformatf("busy_in_flight[%0d]", v), 64'(bok), 64'd1);
        end

        // done is a single pulse and results hold afterwards
        repeat (3) @(posedge clk);
        #1;
        chk("done_single_pulse", 64'(done_reg), 64'd0);
        chk("out_hold", 64'({out_reg, zero_reg}), 64'({vecs[NV-1].r, 1'b0}));

        // start re-pulsed while busy is ignored
        do_op(32'h4040_0000, 32'h4020_0000, 5, lat, bok);
        chk("restart_ignored_out", 64'(out_reg), 64'h40F0_0000);
        chk("restart_ignored_lat", 64'(lat), 64'd27);
        repeat (40) @(posedge clk);
        #1;
        chk("restart_no_second_op", 64'({busy, out_reg}), 64'({1'b0, 32'h40F0_0000}));

        // reset asserted at edge 10 of an operation aborts it
        @(negedge clk);
        op1 = 32'h3FC0_0000; op2 = 32'h3FC0_0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_reset_outputs",
            64'({out_reg, nan_reg, overflow_reg, underflow_reg, zero_reg, busy, done_reg}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (60) begin
            @(posedge clk); #1;
            if (done_reg || busy) seen = 1'b1;
        end
        chk("abort_no_done", 64'(seen), 64'd0);

        do_op(32'h3F80_0000, 32'h4000_0000, 0, lat, bok);
        chk("after_abort_out", 64'(out_reg), 64'h4000_0000);
        chk("after_abort_lat", 64'(lat), 64'd27);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mul_float.md
MUL_FLOAT -- requirements
Module: mul_float

Interface
REQ-001 SHALL provide parameter FLOAT_WIDTH, default 64, IEEE-754 format width; legal values are 64 and 32.
REQ-002 SHALL provide port: clk  input  1  rising-edge clock.
REQ-003 SHALL provide port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL provide port: start  input  1  single-cycle request; captures op1/op2.
REQ-005 SHALL provide port: op1, op2  input  FLOAT_WIDTH  multiplicand and multiplier.
REQ-006 SHALL provide port: out_reg  output  FLOAT_WIDTH  registered product.
REQ-007 SHALL provide ports nan_reg, overflow_reg, underflow_reg, zero_reg, each output 1, as registered result flags.
REQ-008 SHALL provide ports busy  output  1  (operation in flight) and done_reg  output  1  (one-cycle completion pulse).

Function
REQ-009 SHALL implement FSM IDLE -> LOAD -> MUL -> NORM -> IDLE; start is sampled only in IDLE and ignored otherwise.
REQ-010 SHALL, in LOAD, register sign = sign1^sign2, split exponents and fractions, and build significands {1,frac} (F+1 bits, where F = 52 or 23).
REQ-011 SHALL, in MUL, run shift-add over F+1 cycles, one multiplier bit per cycle, into a 2F+2-bit product register.
REQ-012 SHALL, in NORM, shift the product right by 1 and increment the exponent when product MSB = 1 (value in [2,4)); biased exponent = e1 + e2 - bias (+1), computed at EXP_WIDTH+2 bits signed.
REQ-013 SHALL assert done_reg for exactly one cycle on the (F+4)th clock edge after the edge that samples start: 27 edges for FLOAT_WIDTH=32, 56 for 64. Output and flags update on that same edge.
REQ-014 SHALL keep busy high from the edge after start sampling until done_reg asserts; busy is low while done_reg is high.
REQ-015 SHALL treat exponent 0 as zero (flush denormal inputs); exponent all-ones with frac 0 is Inf, with frac non-zero is NaN.
REQ-016 SHALL apply special-case priority: NaN input or Inf*zero -> NAN_VALUE (FFF8_0000_0000_0000 / FFC0_0000) with nan_reg=1; else Inf input -> signed Inf; else zero input -> signed zero with zero_reg=1.
REQ-017 SHALL, when normalized biased exponent >= EXP_MAX, output signed Inf with overflow_reg=1.
REQ-018 SHALL, when normalized biased exponent <= 0, output signed zero with underflow_reg=1 and zero_reg=1.
REQ-019 SHALL hold out_reg and flags stable until the next completion.

Reset
REQ-020 SHALL, on rst_n low, drive IDLE, out_reg=0, all flags=0, busy=0 and done_reg=0 immediately, independent of clk.
REQ-021 SHALL abort an in-flight operation on reset, and SHALL NOT produce done_reg for it after release.

Configuration
REQ-022 SHALL, with MUL_FLOAT_ROUND_EN defined, round to nearest-even in NORM using guard and sticky bits, renormalize on rounding carry, and re-check overflow after rounding; latency is unchanged.
REQ-023 SHALL, without MUL_FLOAT_ROUND_EN, truncate the discarded product bits.

Structure
REQ-024 SHALL place EXP_WIDTH/FRACTION_WIDTH derivation, EXP_SHIFT, EXP_MAX, NAN_VALUE, INF_VALUE and the FSM state encodings in shared package float_pkg, common with the divider.
REQ-025 SHALL instantiate one sub-module, float_classify, twice: per-operand zero/inf/nan decode, also reusable by the divider.

Verification
REQ-026 SHALL verify, at 32-bit: 40400000 * 40200000 -> 40F00000 (3*2.5=7.5), done_reg pulses on the 27th edge after start, all flags 0.
REQ-027 SHALL verify: C0000000 * 3F000000 -> BF800000; 3FC00000 * 3FC00000 -> 40100000 (normalization path).
REQ-028 SHALL verify: 7F800000 * 00000000 -> FFC00000, nan_reg=1; 7F000000 * 40800000 -> 7F800000, overflow_reg=1.
REQ-029 SHALL verify: 00800000 * 00800000 -> 00000000 with underflow_reg=1 and zero_reg=1.
REQ-030 SHALL verify: 3FC00001 * 3FC00001 -> 40100002 with MUL_FLOAT_ROUND_EN and 40100001 without it.
REQ-031 SHALL verify: rst_n pulsed low at edge 10 of an operation -> outputs 0, no done_reg afterwards; start re-pulsed while busy -> ignored, result still from the original operands.
